spi_slave_mode: RTL and testbench

Parametrised successor to the single-mode SPI slave. It supports all four SPI modes (CPOL/CPHA, selected at runtime) and configurable bit order. Each frame can carry any number of back-to-back words. TX uses a one-word valid/ready holding buffer, and the block flags underrun and framing errors. It sits between the board-level SPI pins and the acquisition control and data-path logic, all in the clk domain.

---
 rtl/spi_slave_mode.sv | 185 ++++++++++++++++++
 tb/tb_spi_slave_mode.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_mode.sv
// SPI slave supporting all four CPOL/CPHA modes with multi-word frames,
// a one-word TX holding buffer and underrun/framing error pulses.
module spi_slave_mode #(
    parameter int unsigned           DATA_WIDTH    = 16,
    parameter int unsigned           BIT_CNT_WIDTH = 4,
    parameter bit                    MSB_FIRST     = 1'b1,
    parameter logic [DATA_WIDTH-1:0] TX_IDLE       = '1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ss,
    input  logic                  sck,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  miso_oe,
    input  logic                  cpol,
    input  logic                  cpha,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  busy,
    output logic                  underrun,
    output logic                  frame_err
);

    typedef enum logic {S_IDLE, S_ACTIVE} state_t;

    localparam logic [BIT_CNT_WIDTH-1:0] LAST_BIT = BIT_CNT_WIDTH'(DATA_WIDTH - 1);

    state_t                   state_q;
    logic                     ss_meta_q, ss_sync_q, ss_prev_q;
    logic                     sck_meta_q, sck_sync_q, sck_prev_q;
    logic                     mosi_meta_q, mosi_sync_q;
    logic [1:0]               mode_q;
    logic [BIT_CNT_WIDTH-1:0] bit_cnt_q;
    logic [DATA_WIDTH-1:0]    rx_sr_q, tx_sr_q, hold_q;
    logic                     miso_q, miso_oe_q, tx_ready_q, rx_valid_q;
    logic [DATA_WIDTH-1:0]    rx_data_q;
    logic                     busy_q, underrun_q, frame_err_q;

    logic                  ss_fall, ss_rise, sck_rise, sck_fall;
    logic                  lead_edge, trail_edge, sample_edge, shift_edge;
    logic                  start, word_done, load, hold_full, bypass;
    logic [DATA_WIDTH-1:0] load_word_d, rx_word_d;

    function automatic logic first_bit(input logic [DATA_WIDTH-1:0] w);
        return MSB_FIRST ? w[DATA_WIDTH-1] : w[0];
    endfunction

    function automatic logic [DATA_WIDTH-1:0] shift_out(input logic [DATA_WIDTH-1:0] w);
        return MSB_FIRST ? {w[DATA_WIDTH-2:0], 1'b1} : {1'b1, w[DATA_WIDTH-1:1]};
    endfunction

    assign ss_fall     = ss_prev_q & ~ss_sync_q;
    assign ss_rise     = ~ss_prev_q & ss_sync_q;
    assign sck_rise    = ~sck_prev_q & sck_sync_q;
    assign sck_fall    = sck_prev_q & ~sck_sync_q;
    assign lead_edge   = mode_q[1] ? sck_fall : sck_rise;
    assign trail_edge  = mode_q[1] ? sck_rise : sck_fall;
    assign sample_edge = mode_q[0] ? trail_edge : lead_edge;
    assign shift_edge  = mode_q[0] ? lead_edge : trail_edge;

    assign start     = (state_q == S_IDLE) && ss_fall;
    assign word_done = (state_q == S_ACTIVE) && !ss_rise && sample_edge && (bit_cnt_q == LAST_BIT);
    assign load      = start || word_done;
    assign hold_full = ~tx_ready_q;
    assign bypass    = load && !hold_full && tx_valid;

    always_comb begin
        load_word_d = TX_IDLE;
        if (hold_full)
            load_word_d = hold_q;
        else if (tx_valid)
            load_word_d = tx_data;
        rx_word_d = MSB_FIRST ? {rx_sr_q[DATA_WIDTH-2:0], mosi_sync_q}
                              : {mosi_sync_q, rx_sr_q[DATA_WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            // ss chain clears low so a frame only starts after ss is seen high
            ss_meta_q   <= 1'b0;
            ss_sync_q   <= 1'b0;
            ss_prev_q   <= 1'b0;
            sck_meta_q  <= 1'b0;
            sck_sync_q  <= 1'b0;
            sck_prev_q  <= 1'b0;
            mosi_meta_q <= 1'b0;
            mosi_sync_q <= 1'b0;
            mode_q      <= '0;
            bit_cnt_q   <= '0;
            rx_sr_q     <= '0;
            tx_sr_q     <= TX_IDLE;
            hold_q      <= '0;
            miso_q      <= 1'b1;
            miso_oe_q   <= 1'b0;
            tx_ready_q  <= 1'b1;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            underrun_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            ss_meta_q   <= ss;
            ss_sync_q   <= ss_meta_q;
            ss_prev_q   <= ss_sync_q;
            sck_meta_q  <= sck;
            sck_sync_q  <= sck_meta_q;
            sck_prev_q  <= sck_sync_q;
            mosi_meta_q <= mosi;
            mosi_sync_q <= mosi_meta_q;
            rx_valid_q  <= 1'b0;
            underrun_q  <= 1'b0;
            frame_err_q <= 1'b0;

            if (ss_sync_q)
                mode_q <= {cpol, cpha};

            if (tx_valid && tx_ready_q && !bypass) begin
                hold_q     <= tx_data;
                tx_ready_q <= 1'b0;
            end

            if (load) begin
                if (hold_full)
                    tx_ready_q <= 1'b1;
                underrun_q <= !hold_full && !tx_valid;
            end

            case (state_q)
                S_IDLE: begin
                    if (ss_fall) begin
                        state_q   <= S_ACTIVE;
                        busy_q    <= 1'b1;
                        miso_oe_q <= 1'b1;
                        bit_cnt_q <= '0;
                        // CPHA=0 drives the first bit before any clock edge
                        if (!mode_q[0]) begin
                            miso_q  <= first_bit(load_word_d);
                            tx_sr_q <= shift_out(load_word_d);
                        end else begin
                            tx_sr_q <= load_word_d;
                        end
                    end
                end
                S_ACTIVE: begin
                    if (ss_rise) begin
                        state_q     <= S_IDLE;
                        busy_q      <= 1'b0;
                        miso_oe_q   <= 1'b0;
                        miso_q      <= 1'b1;
                        frame_err_q <= (bit_cnt_q != '0);
                    end else if (sample_edge) begin
                        rx_sr_q <= rx_word_d;
                        if (bit_cnt_q == LAST_BIT) begin
                            rx_data_q  <= rx_word_d;
                            rx_valid_q <= 1'b1;
                            bit_cnt_q  <= '0;
                            tx_sr_q    <= load_word_d;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + BIT_CNT_WIDTH'(1);
                        end
                    end else if (shift_edge) begin
                        miso_q  <= first_bit(tx_sr_q);
                        tx_sr_q <= shift_out(tx_sr_q);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign miso      = miso_q;
    assign miso_oe   = miso_oe_q;
    assign tx_ready  = tx_ready_q;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign busy      = busy_q;
    assign underrun  = underrun_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_slave_mode.sv
// Directed and randomized bench for spi_slave_mode: the bench acts as SPI
// master and predicts miso/rx words and error pulses from the frame plan.
module tb_spi_slave_mode;

    localparam int H = 6;

    logic        clk = 1'b0;
    logic        rst_n, ss, sck, mosi, miso, miso_oe, cpol, cpha;
    logic [15:0] tx_data, rx_data;
    logic        tx_valid, tx_ready, rx_valid, busy, underrun, frame_err;

    spi_slave_mode #(
        .DATA_WIDTH   (16),
        .BIT_CNT_WIDTH(4),
        .MSB_FIRST    (1'b1),
        .TX_IDLE      (16'hFFFF)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ss(ss), .sck(sck), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .cpol(cpol), .cpha(cpha),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
        .underrun(underrun), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    int unsigned cyc = 0;
    logic [15:0] rxq[$];
    int unsigned rxcyc[$];
    int unsigned urcyc[$];
    int          fe_cnt = 0;
    int          both_cnt = 0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (rx_valid) begin
            rxq.push_back(rx_data);
            rxcyc.push_back(cyc);
        end
        if (underrun) urcyc.push_back(cyc);
        if (frame_err) fe_cnt = fe_cnt + 1;
        if (rx_valid && frame_err) both_cnt = both_cnt + 1;
    end

    bit          m_cpol, m_cpha, tog_en;
    int          f_n;
    logic [15:0] f_tx[0:3];
    bit          f_sup[0:3];
    logic [15:0] f_mo[0:2];
    logic [15:0] f_mi[0:2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_mode(input bit p, input bit h);
        m_cpol = p; m_cpha = h;
        cpol = p; cpha = h; sck = p;
        wait_clk(6);
    endtask

    task automatic push(input logic [15:0] w);
        int k;
        tx_data = w; tx_valid = 1'b1; k = 0;
        while (!tx_ready && k < 50) begin
            wait_clk(1);
            k++;
        end
        chk("push_ready", {31'd0, tx_ready}, 32'd1);
        wait_clk(1);
        tx_valid = 1'b0;
    endtask

    task automatic frame_start();
        ss = 1'b0;
        wait_clk(6);
    endtask

    task automatic frame_end();
        wait_clk(H);
        ss = 1'b1;
        wait_clk(8);
    endtask

    task automatic xfer_bits(input logic [15:0] mo, input int nb, output logic [15:0] mi);
        mi = '0;
        for (int i = 0; i < nb; i++) begin
            if (tog_en && i == 6)  cpol = ~m_cpol;
            if (tog_en && i == 10) cpol = m_cpol;
            if (!m_cpha) begin
                mosi = mo[15-i];
                wait_clk(H);
                sck = ~m_cpol;
                mi[15-i] = miso;
                wait_clk(H);
                sck = m_cpol;
            end else begin
                sck = ~m_cpol;
                mosi = mo[15-i];
                wait_clk(H);
                sck = m_cpol;
                mi[15-i] = miso;
                wait_clk(H);
            end
        end
    endtask

    task automatic run_frame(input string tag);
        int          ur0, rx0, fe0, exp_ur;
        logic [15:0] got;
        ur0 = urcyc.size(); rx0 = rxq.size(); fe0 = fe_cnt;
        if (f_sup[0]) push(f_tx[0]);
        frame_start();
        chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
        chk({tag, "_oe"}, {31'd0, miso_oe}, 32'd1);
        for (int k = 0; k < f_n; k++) begin
            if (f_sup[k+1]) push(f_tx[k+1]);
            xfer_bits(f_mo[k], 16, f_mi[k]);
        end
        frame_end();
        chk({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
        chk({tag, "_oe_end"}, {31'd0, miso_oe}, 32'd0);
        chk({tag, "_miso_idle"}, {31'd0, miso}, 32'd1);
        exp_ur = 0;
        for (int k = 0; k <= f_n; k++) if (!f_sup[k]) exp_ur++;
        chk({tag, "_underruns"}, urcyc.size() - ur0, exp_ur);
        chk({tag, "_rxcount"}, rxq.size() - rx0, f_n);
        chk({tag, "_frame_err"}, fe_cnt - fe0, 0);
        for (int k = 0; k < f_n; k++) begin
            chk($sformatf("%s_miso_w%0d", tag, k), {16'd0, f_mi[k]},
                {16'd0, f_sup[k] ? f_tx[k] : 16'hFFFF});
            got = (rxq.size() > rx0 + k) ? rxq[rx0 + k] : 16'hxxxx;
            chk($sformatf("%s_rx_w%0d", tag, k), {16'd0, got}, {16'd0, f_mo[k]});
        end
    endtask

    initial begin
        int          ur0, rx0, fe0;
        logic [15:0] dummy;
        rst_n = 1'b0; ss = 1'b1; sck = 1'b0; mosi = 1'b0; cpol = 1'b0; cpha = 1'b0;
        tx_valid = 1'b0; tx_data = '0; tog_en = 1'b0; m_cpol = 1'b0; m_cpha = 1'b0;
        wait_clk(3);
        chk("rst_miso", {31'd0, miso}, 32'd1);
        chk("rst_oe", {31'd0, miso_oe}, 32'd0);
        chk("rst_rx_data", {16'd0, rx_data}, 32'd0);
        chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        chk("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_flags", {30'd0, underrun, frame_err}, 32'd0);
        rst_n = 1'b1;
        wait_clk(4);

        // mode 0, single word, next load covered so no underrun
        set_mode(1'b0, 1'b0);
        f_n = 1; f_tx[0] = 16'hA55A; f_tx[1] = 16'h0001; f_sup[0] = 1; f_sup[1] = 1;
        f_mo[0] = 16'h1234;
        run_frame("mode0");

        // modes 1..3 with a cpol pin toggle inside the frame
        for (int m = 1; m < 4; m++) begin
            set_mode(m[1], m[0]);
            tog_en = 1'b1;
            f_n = 1; f_tx[0] = 16'hC3F0; f_tx[1] = 16'h0002; f_sup[0] = 1; f_sup[1] = 1;
            f_mo[0] = 16'h0F3C;
            run_frame($sformatf("mode%0d", m));
            tog_en = 1'b0;
        end

        // three words, data for first two only
        set_mode(1'b0, 1'b0);
        ur0 = urcyc.size(); rx0 = rxq.size();
        f_n = 3; f_tx[0] = 16'h1111; f_tx[1] = 16'h2222;
        f_sup[0] = 1; f_sup[1] = 1; f_sup[2] = 0; f_sup[3] = 0;
        f_mo[0] = 16'hABCD; f_mo[1] = 16'h7E81; f_mo[2] = 16'h0055;
        run_frame("three");
        chk("three_underrun_at_load3",
            (urcyc.size() > ur0 && rxq.size() > rx0 + 1) ? urcyc[ur0] : 0,
            (rxcyc.size() > rx0 + 1) ? rxcyc[rx0 + 1] : 32'hFFFF_FFFF);

        // ss raised after 9 bits
        fe0 = fe_cnt; rx0 = rxq.size();
        push(16'h4444);
        frame_start();
        xfer_bits(16'h1357, 9, dummy);
        frame_end();
        chk("ferr_pulse", fe_cnt - fe0, 1);
        chk("ferr_no_rx", rxq.size() - rx0, 0);
        f_n = 1; f_tx[0] = 16'h5A5A; f_tx[1] = 16'h0003; f_sup[0] = 1; f_sup[1] = 1;
        f_mo[0] = 16'hBEEF;
        run_frame("after_ferr");

        // bypass: tx_valid only in the load cycle with an empty buffer
        ur0 = urcyc.size(); rx0 = rxq.size();
        ss = 1'b0;
        wait_clk(2);
        tx_data = 16'h6D29; tx_valid = 1'b1;
        wait_clk(1);
        tx_valid = 1'b0;
        chk("byp_tx_ready", {31'd0, tx_ready}, 32'd1);
        chk("byp_busy", {31'd0, busy}, 32'd1);
        wait_clk(3);
        push(16'h0004);
        xfer_bits(16'h3C3C, 16, f_mi[0]);
        frame_end();
        chk("byp_miso", {16'd0, f_mi[0]}, 32'h6D29);
        chk("byp_no_underrun", urcyc.size() - ur0, 0);
        chk("byp_rx", (rxq.size() > rx0) ? {16'd0, rxq[rx0]} : 32'hFFFF_FFFF, 32'h3C3C);

        // reset pulse mid-word
        rx0 = rxq.size();
        push(16'h7777);
        frame_start();
        xfer_bits(16'hF0F0, 5, dummy);
        rst_n = 1'b0;
        wait_clk(1);
        rst_n = 1'b1;
        chk("mrst_oe", {31'd0, miso_oe}, 32'd0);
        chk("mrst_busy", {31'd0, busy}, 32'd0);
        chk("mrst_miso", {31'd0, miso}, 32'd1);
        chk("mrst_rx_data", {16'd0, rx_data}, 32'd0);
        chk("mrst_tx_ready", {31'd0, tx_ready}, 32'd1);
        xfer_bits(16'h0F0F, 11, dummy);
        chk("mrst_ignored_busy", {31'd0, busy}, 32'd0);
        chk("mrst_ignored_rx", rxq.size() - rx0, 0);
        frame_end();
        f_n = 1; f_tx[0] = 16'h9ABC; f_tx[1] = 16'h0005; f_sup[0] = 1; f_sup[1] = 1;
        f_mo[0] = 16'h2468;
        run_frame("post_rst");

        // randomized frames
        for (int r = 0; r < 6; r++) begin
            int unsigned m;
            m = $urandom_range(0, 3);
            set_mode(m[1], m[0]);
            f_n = $urandom_range(1, 3);
            for (int k = 0; k < 4; k++) begin
                f_tx[k] = 16'($urandom);
                f_sup[k] = 1'($urandom);
            end
            for (int k = 0; k < 3; k++) f_mo[k] = 16'($urandom);
            run_frame($sformatf("rand%0d", r));
        end

        chk("rxv_ferr_overlap", both_cnt, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
